// File: rtl/udc_pkg.sv
// Shared constants for the up/down modulo counter.
// Holds the direction encodings, the default parameter values and the
// per-edge operation type used to decode control priority.
package udc_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int          UDC_N_DEF   = 7;
    localparam int unsigned UDC_MAX_DEF = 127;
    localparam int          UDC_WN_DEF  = 8;

    // Operation selected on a clock edge after clr > load > en priority.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_CLR  = 2'd1,
        OP_LOAD = 2'd2,
        OP_CNT  = 2'd3
    } udc_op_e;

endpackage : udc_pkg

// File: rtl/udc_wrap_tally.sv
// Wrap tally for the up/down modulo counter.
// Counts wrap events modulo 2^WN and rolls over silently.
// Only instantiated when the counter is built with UDC_WRAPCNT_EN.
module udc_wrap_tally #(
    parameter int WN = 8
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [WN-1:0] cnt
);

    logic [WN-1:0] cnt_q;
    logic [WN-1:0] cnt_d;

    // Next tally: clear wins, otherwise count one per wrap event.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + WN'(1);
        end
    end

    // Tally register with asynchronous clear.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : udc_wrap_tally

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with synchronous clear, clamped load and a
// one-cycle wrap pulse. Counts 0..MAX in either direction.
// Optional feature: define UDC_WRAPCNT_EN to add the `wraps` port, a
// WN-bit tally of wrap events.
module updown_mod_counter
    import udc_pkg::*;
#(
    parameter int          N   = UDC_N_DEF,
    parameter int unsigned MAX = UDC_MAX_DEF,
    parameter int          WN  = UDC_WN_DEF
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [N-1:0]  load_val,
    input  logic          en,
    input  logic          up,
    output logic [N-1:0]  q,
    output logic          done
`ifdef UDC_WRAPCNT_EN
    ,
    output logic [WN-1:0] wraps
`endif
);

    // Reject illegal configurations at elaboration time.
    if (N < 2 || N > 32) begin : g_bad_n
        $fatal(1, "updown_mod_counter: N=%0d outside 2..32", N);
    end
    if (MAX < 1 || 64'(MAX) > ((64'd1 << N) - 64'd1)) begin : g_bad_max
        $fatal(1, "updown_mod_counter: MAX=%0d outside 1..2^N-1", MAX);
    end
    if (WN < 1) begin : g_bad_wn
        $fatal(1, "updown_mod_counter: WN=%0d must be at least 1", WN);
    end

    localparam logic [N-1:0] MAX_V = N'(MAX);

    udc_op_e      op;
    logic [N-1:0] q_q;
    logic [N-1:0] q_d;
    logic         done_q;
    logic         done_d;

    // Resolve the control inputs into a single operation, clr first.
    always_comb begin
        if (clr) begin
            op = OP_CLR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (en) begin
            op = OP_CNT;
        end else begin
            op = OP_HOLD;
        end
    end

    // Next count and wrap pulse; the MAX compare makes the modulo explicit.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        q_d    = q_q;
        done_d = 1'b0;
        unique case (op)
            OP_CLR:  q_d = '0;
            OP_LOAD: q_d = (load_val > MAX_V) ? MAX_V : load_val;
            OP_CNT: begin
                unique case (up)
                    DIR_UP: begin
                        if (q_q == MAX_V) begin
                            q_d    = '0;
                            done_d = 1'b1;
                        end else begin
                            q_d = q_q + N'(1);
                        end
                    end
                    DIR_DN: begin
                        if (q_q == '0) begin
                            q_d    = MAX_V;
                            done_d = 1'b1;
                        end else begin
                            q_d = q_q - N'(1);
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Count and wrap-pulse registers with asynchronous reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            q_q    <= '0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading
            // the pre-edge value of the others, like real flops.
            q_q    <= q_d;
            done_q <= done_d;
        end
    end

    assign q    = q_q;
    assign done = done_q;

`ifdef UDC_WRAPCNT_EN
    // Tally advances on the same edge that raises done; load never counts.
    udc_wrap_tally #(
        .WN (WN)
    ) u_wrap_tally (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (op == OP_CLR),
        .inc    (done_d),
        .cnt    (wraps)
    );
`endif

endmodule : updown_mod_counter
